// File: rtl/fdc_pkg.sv
// Shared types and defaults for the FDC sector buffer.
package fdc_pkg;

  localparam int FDC_SECTOR_BYTES   = 512;
  localparam int FDC_ADDR_W         = 9;
  localparam int FDC_LBA_W          = 32;
  localparam int FDC_TIMEOUT_CYCLES = 50_000_000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_REQ,
    ST_RD_XFER,
    ST_WR_REQ,
    ST_WR_XFER,
    ST_FINISH
  } fdc_sbuf_state_t;

endpackage

// File: rtl/fdc_sector_buffer_if.sv
// FDC request/buffer port and HPS sd block port of the sector buffer.
interface fdc_sector_buffer_if
  import fdc_pkg::*;
#(
  parameter int ADDR_W = FDC_ADDR_W,
  parameter int LBA_W  = FDC_LBA_W
);

  logic              req_rd;
  logic              req_wr;
  logic [LBA_W-1:0]  req_lba;
  logic              busy;
  logic              done;
  logic              error;
  logic [ADDR_W-1:0] buf_addr;
  logic [7:0]        buf_rd_data;
  logic              buf_wr_en;
  logic [7:0]        buf_wr_data;

  logic [LBA_W-1:0]  sd_lba;
  logic              sd_rd;
  logic              sd_wr;
  logic              sd_ack;
  logic [ADDR_W-1:0] sd_buff_addr;
  logic [7:0]        sd_buff_dout;
  logic              sd_buff_wr;
  logic [7:0]        sd_buff_din;
  logic              img_mounted;
  logic              img_present;
  logic              img_readonly;

  modport slave (
    input  req_rd, req_wr, req_lba, buf_addr, buf_wr_en, buf_wr_data,
    input  sd_ack, sd_buff_addr, sd_buff_dout, sd_buff_wr,
    input  img_mounted, img_present, img_readonly,
    output busy, done, error, buf_rd_data,
    output sd_lba, sd_rd, sd_wr, sd_buff_din
  );

  modport master (
    output req_rd, req_wr, req_lba, buf_addr, buf_wr_en, buf_wr_data,
    output sd_ack, sd_buff_addr, sd_buff_dout, sd_buff_wr,
    output img_mounted, img_present, img_readonly,
    input  busy, done, error, buf_rd_data,
    input  sd_lba, sd_rd, sd_wr, sd_buff_din
  );

endinterface

// File: rtl/sector_dpram.sv
// One-sector true dual-port byte RAM with registered reads; port A = FDC, port B = HPS.
module sector_dpram #(
  parameter int DEPTH  = 512,
  parameter int ADDR_W = 9
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [7:0]        a_wdata,
  output logic [7:0]        a_rdata,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [7:0]        b_wdata,
  output logic [7:0]        b_rdata
);

  logic [7:0] mem_q [DEPTH];
  logic [7:0] a_rdata_q;
  logic [7:0] b_rdata_q;

  // The two write enables are mutually exclusive by construction (busy vs. not busy).
  always_ff @(posedge clk) begin
    if (a_we) mem_q[a_addr] <= a_wdata;
    if (b_we) mem_q[b_addr] <= b_wdata;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_rdata_q <= 8'h00;
      b_rdata_q <= 8'h00;
    end else begin
      a_rdata_q <= mem_q[a_addr];
      b_rdata_q <= mem_q[b_addr];
    end
  end

  assign a_rdata = a_rdata_q;
  assign b_rdata = b_rdata_q;

endmodule

// File: rtl/fdc_sector_buffer.sv
// SD-side sector buffer for the FDC: one-sector RAM, last-LBA cache, HPS sd block handshake.
// IDLE wait | RD_REQ/WR_REQ hold sd_rd/sd_wr until ack | RD_XFER/WR_XFER HPS moving data | FINISH done + cache update
module fdc_sector_buffer
  import fdc_pkg::*;
#(
  parameter int SECTOR_BYTES   = FDC_SECTOR_BYTES,
  parameter int ADDR_W         = FDC_ADDR_W,
  parameter int LBA_W          = FDC_LBA_W,
  parameter int TIMEOUT_CYCLES = FDC_TIMEOUT_CYCLES
) (
  input  logic               clk,
  input  logic               reset_n,
  fdc_sector_buffer_if.slave bus
);

  localparam int              TO_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  fdc_sbuf_state_t  state_q;
  logic             busy_q;
  logic             done_q;
  logic             error_q;
  logic             sd_rd_q;
  logic             sd_wr_q;
  logic             ack_q;
  logic             cache_valid_q;
  logic [LBA_W-1:0] sd_lba_q;
  logic [LBA_W-1:0] cached_lba_q;
  logic [TO_W-1:0]  to_cnt_q;

  logic buf_we;
  logic hps_we;
  logic cache_hit;

  assign buf_we    = bus.buf_wr_en && !busy_q;
  // Accept HPS bytes from the very cycle ack rises, before the FSM has moved to RD_XFER.
  assign hps_we    = bus.sd_buff_wr &&
                     ((state_q == ST_RD_XFER) || ((state_q == ST_RD_REQ) && bus.sd_ack));
  assign cache_hit = cache_valid_q && !bus.img_mounted && !buf_we &&
                     (bus.req_lba == cached_lba_q);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      error_q       <= 1'b0;
      sd_rd_q       <= 1'b0;
      sd_wr_q       <= 1'b0;
      ack_q         <= 1'b0;
      cache_valid_q <= 1'b0;
      sd_lba_q      <= '0;
      cached_lba_q  <= '0;
      to_cnt_q      <= '0;
    end else begin
      done_q  <= 1'b0;
      error_q <= 1'b0;
      ack_q   <= bus.sd_ack;
      if (buf_we || bus.img_mounted) cache_valid_q <= 1'b0;

      if ((state_q != ST_IDLE) && !bus.img_present) begin
        state_q       <= ST_IDLE;
        busy_q        <= 1'b0;
        sd_rd_q       <= 1'b0;
        sd_wr_q       <= 1'b0;
        error_q       <= 1'b1;
        cache_valid_q <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (bus.req_rd) begin
              if (!bus.img_present) begin
                error_q <= 1'b1;
              end else if (cache_hit) begin
                done_q <= 1'b1;
              end else begin
                sd_lba_q      <= bus.req_lba;
                sd_rd_q       <= 1'b1;
                busy_q        <= 1'b1;
                cache_valid_q <= 1'b0;
                to_cnt_q      <= '0;
                state_q       <= ST_RD_REQ;
              end
            end else if (bus.req_wr) begin
              if (!bus.img_present || bus.img_readonly) begin
                error_q <= 1'b1;
              end else begin
                sd_lba_q <= bus.req_lba;
                sd_wr_q  <= 1'b1;
                busy_q   <= 1'b1;
                to_cnt_q <= '0;
                state_q  <= ST_WR_REQ;
              end
            end
          end

          ST_RD_REQ, ST_WR_REQ: begin
            if (bus.sd_ack) begin
              sd_rd_q <= 1'b0;
              sd_wr_q <= 1'b0;
              state_q <= (state_q == ST_RD_REQ) ? ST_RD_XFER : ST_WR_XFER;
            end else if (to_cnt_q == TO_LAST) begin
              sd_rd_q <= 1'b0;
              sd_wr_q <= 1'b0;
              busy_q  <= 1'b0;
              error_q <= 1'b1;
              state_q <= ST_IDLE;
            end else begin
              to_cnt_q <= to_cnt_q + 1'b1;
            end
          end

          ST_RD_XFER, ST_WR_XFER: begin
            if (ack_q && !bus.sd_ack) state_q <= ST_FINISH;
          end

          ST_FINISH: begin
            done_q        <= 1'b1;
            busy_q        <= 1'b0;
            cached_lba_q  <= sd_lba_q;
            cache_valid_q <= !bus.img_mounted;
            state_q       <= ST_IDLE;
          end

          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.error  = error_q;
  assign bus.sd_rd  = sd_rd_q;
  assign bus.sd_wr  = sd_wr_q;
  assign bus.sd_lba = sd_lba_q;

  sector_dpram #(
    .DEPTH  (SECTOR_BYTES),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk     (clk),
    .reset_n (reset_n),
    .a_we    (buf_we),
    .a_addr  (bus.buf_addr),
    .a_wdata (bus.buf_wr_data),
    .a_rdata (bus.buf_rd_data),
    .b_we    (hps_we),
    .b_addr  (bus.sd_buff_addr),
    .b_wdata (bus.sd_buff_dout),
    .b_rdata (bus.sd_buff_din)
  );

endmodule

// File: tb/tb_fdc_sector_buffer.sv
// Directed bench for fdc_sector_buffer: IDLE decision table plus hand-written transfer sequences.
module tb_fdc_sector_buffer;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  fdc_sector_buffer_if bus_if ();

  fdc_sector_buffer #(
    .TIMEOUT_CYCLES (100)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus_if)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rd;
    logic        wr;
    logic        pres;
    logic        ro;
    logic [31:0] lba;
    logic [4:0]  exp;   // {done, error, busy, sd_rd, sd_wr} one cycle after the request
  } vec_t;

  localparam int NVEC = 10;
  vec_t vecs [NVEC];

  int  checks = 0;
  int  errors = 0;
  int  cyc;
  int  bad;
  bit  ok;
  bit  rd_dropped_early;
  logic [8:0] raddr [5];

  function automatic logic [4:0] flags();
    return {bus_if.done, bus_if.error, bus_if.busy, bus_if.sd_rd, bus_if.sd_wr};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic issue(input logic rd, input logic wr, input logic [31:0] lba);
    @(negedge clk);
    bus_if.req_rd  = rd;
    bus_if.req_wr  = wr;
    bus_if.req_lba = lba;
    @(negedge clk);
    bus_if.req_rd  = 1'b0;
    bus_if.req_wr  = 1'b0;
  endtask

  // HPS acks for one cycle without moving data; done must follow two cycles after ack falls.
  task automatic hps_complete(input string name);
    logic d0;
    @(negedge clk);
    bus_if.sd_ack = 1'b1;
    @(negedge clk);
    check({name, "_req_drop"}, 32'({bus_if.sd_rd, bus_if.sd_wr}), 32'd0);
    bus_if.sd_ack = 1'b0;
    @(negedge clk);
    d0 = bus_if.done;
    @(negedge clk);
    check({name, "_done"}, 32'({d0, bus_if.done, bus_if.busy}), 32'b010);
  endtask

  initial begin
    vecs[0] = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h20, 5'b00110};
    vecs[1] = '{1'b1, 1'b0, 1'b1, 1'b0, 32'h20, 5'b10000};
    vecs[2] = '{1'b0, 1'b1, 1'b1, 1'b1, 32'h21, 5'b01000};
    vecs[3] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h20, 5'b01000};
    vecs[4] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h21, 5'b01000};
    vecs[5] = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h22, 5'b00101};
    vecs[6] = '{1'b1, 1'b0, 1'b1, 1'b0, 32'h22, 5'b10000};
    vecs[7] = '{1'b1, 1'b0, 1'b1, 1'b0, 32'h20, 5'b00110};
    vecs[8] = '{1'b1, 1'b0, 1'b1, 1'b1, 32'h20, 5'b10000};
    vecs[9] = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h00, 5'b00000};
    raddr[0] = 9'd0;
    raddr[1] = 9'd3;
    raddr[2] = 9'd255;
    raddr[3] = 9'd256;
    raddr[4] = 9'd511;

    bus_if.req_rd       = 1'b0;
    bus_if.req_wr       = 1'b0;
    bus_if.req_lba      = 32'h0;
    bus_if.buf_addr     = 9'h0;
    bus_if.buf_wr_en    = 1'b0;
    bus_if.buf_wr_data  = 8'h0;
    bus_if.sd_ack       = 1'b0;
    bus_if.sd_buff_addr = 9'h0;
    bus_if.sd_buff_dout = 8'h0;
    bus_if.sd_buff_wr   = 1'b0;
    bus_if.img_mounted  = 1'b0;
    bus_if.img_present  = 1'b1;
    bus_if.img_readonly = 1'b0;

    repeat (2) @(negedge clk);
    check("reset_flags", 32'(flags()), 32'd0);
    check("reset_sd_lba", bus_if.sd_lba, 32'd0);
    check("reset_rdata", 32'({bus_if.buf_rd_data, bus_if.sd_buff_din}), 32'd0);
    reset_n = 1'b1;

    // IDLE decision table
    for (int i = 0; i < NVEC; i++) begin
      @(negedge clk);
      bus_if.req_rd       = vecs[i].rd;
      bus_if.req_wr       = vecs[i].wr;
      bus_if.img_present  = vecs[i].pres;
      bus_if.img_readonly = vecs[i].ro;
      bus_if.req_lba      = vecs[i].lba;
      @(negedge clk);
      check($sformatf("vec%0d_flags", i), 32'(flags()), 32'(vecs[i].exp));
      bus_if.req_rd       = 1'b0;
      bus_if.req_wr       = 1'b0;
      bus_if.img_present  = 1'b1;
      bus_if.img_readonly = 1'b0;
      if (vecs[i].exp[2]) begin
        check($sformatf("vec%0d_sd_lba", i), bus_if.sd_lba, vecs[i].lba);
        hps_complete($sformatf("vec%0d", i));
      end
    end

    // Read miss with data: sd_rd held for 10 cycles until ack
    issue(1'b1, 1'b0, 32'h12);
    ok = 1'b1;
    for (int k = 0; k < 10; k++) begin
      if (bus_if.sd_rd !== 1'b1) ok = 1'b0;
      @(negedge clk);
    end
    check("rdmiss_sd_rd_held", 32'(ok), 32'd1);
    bus_if.sd_ack = 1'b1;
    @(negedge clk);
    check("rdmiss_sd_rd_drop", 32'(bus_if.sd_rd), 32'd0);
    for (int a = 0; a < 512; a++) begin
      bus_if.sd_buff_addr = a[8:0];
      bus_if.sd_buff_dout = a[7:0] ^ 8'h5A;
      bus_if.sd_buff_wr   = 1'b1;
      @(negedge clk);
    end
    bus_if.sd_buff_wr = 1'b0;
    bus_if.sd_ack     = 1'b0;
    @(negedge clk);
    check("rdmiss_done_early", 32'(bus_if.done), 32'd0);
    @(negedge clk);
    check("rdmiss_done", 32'({bus_if.done, bus_if.busy}), 32'b10);
    for (int j = 0; j < 5; j++) begin
      @(negedge clk);
      bus_if.buf_addr = raddr[j];
      @(negedge clk);
      check($sformatf("rdmiss_buf_%0d", raddr[j]), 32'(bus_if.buf_rd_data),
            32'(raddr[j][7:0] ^ 8'h5A));
    end

    // Cache hit, then neighbouring miss
    issue(1'b1, 1'b0, 32'h12);
    check("hit12", 32'(flags()), 32'b10000);
    issue(1'b1, 1'b0, 32'h13);
    check("miss13", 32'(flags()), 32'b00110);
    hps_complete("miss13");

    // FDC fills buffer with 0xA5, then sector write to LBA 7
    for (int a = 0; a < 512; a++) begin
      @(negedge clk);
      bus_if.buf_addr    = a[8:0];
      bus_if.buf_wr_data = 8'hA5;
      bus_if.buf_wr_en   = 1'b1;
    end
    @(negedge clk);
    bus_if.buf_wr_en = 1'b0;
    issue(1'b0, 1'b1, 32'h7);
    check("wr7_flags", 32'(flags()), 32'b00101);
    check("wr7_sd_lba", bus_if.sd_lba, 32'h7);
    repeat (3) @(negedge clk);
    bus_if.sd_ack = 1'b1;
    @(negedge clk);
    check("wr7_sd_wr_drop", 32'(bus_if.sd_wr), 32'd0);
    bad = 0;
    for (int a = 0; a < 512; a++) begin
      bus_if.sd_buff_addr = a[8:0];
      bus_if.sd_buff_wr   = 1'b1;
      @(negedge clk);
      if (bus_if.sd_buff_din !== 8'hA5) bad++;
    end
    bus_if.sd_buff_wr = 1'b0;
    check("wr7_hps_data", 32'(bad), 32'd0);
    bus_if.sd_ack = 1'b0;
    @(negedge clk);
    check("wr7_done_early", 32'(bus_if.done), 32'd0);
    @(negedge clk);
    check("wr7_done", 32'({bus_if.done, bus_if.busy}), 32'b10);
    issue(1'b1, 1'b0, 32'h7);
    check("hit7", 32'(flags()), 32'b10000);

    // Timeout: no ack, error exactly 100 cycles after the request is taken
    issue(1'b1, 1'b0, 32'h30);
    check("to_start", 32'(flags()), 32'b00110);
    cyc = 0;
    rd_dropped_early = 1'b0;
    while (!bus_if.error && cyc < 200) begin
      if (!bus_if.sd_rd) rd_dropped_early = 1'b1;
      @(negedge clk);
      cyc++;
    end
    check("to_cycle", 32'(cyc), 32'd100);
    check("to_flags", 32'({rd_dropped_early, flags()}), 32'b001000);

    // img_present falls during RD_XFER
    issue(1'b1, 1'b0, 32'h40);
    bus_if.sd_ack = 1'b1;
    @(negedge clk);
    bus_if.img_present = 1'b0;
    @(negedge clk);
    check("eject_flags", 32'(flags()), 32'b01000);
    bus_if.sd_ack      = 1'b0;
    bus_if.img_present = 1'b1;
    issue(1'b1, 1'b0, 32'h40);
    check("eject_refetch", 32'(flags()), 32'b00110);
    hps_complete("refetch40");

    // Requests and buffer writes while busy are ignored
    issue(1'b1, 1'b0, 32'h60);
    @(negedge clk);
    bus_if.req_rd      = 1'b1;
    bus_if.req_wr      = 1'b1;
    bus_if.req_lba     = 32'h61;
    bus_if.buf_addr    = 9'd5;
    bus_if.buf_wr_data = 8'h11;
    bus_if.buf_wr_en   = 1'b1;
    @(negedge clk);
    bus_if.req_rd    = 1'b0;
    bus_if.req_wr    = 1'b0;
    bus_if.buf_wr_en = 1'b0;
    check("busy_ignore_flags", 32'(flags()), 32'b00110);
    check("busy_ignore_lba", bus_if.sd_lba, 32'h60);
    hps_complete("busy60");
    @(negedge clk);
    check("busy_no_extra_done", 32'({bus_if.done, bus_if.error}), 32'd0);
    @(negedge clk);
    check("busy_buf_protect", 32'(bus_if.buf_rd_data), 32'hA5);

    // img_mounted and accepted FDC writes both invalidate the cache
    @(negedge clk);
    bus_if.img_mounted = 1'b1;
    @(negedge clk);
    bus_if.img_mounted = 1'b0;
    issue(1'b1, 1'b0, 32'h60);
    check("mount_miss", 32'(flags()), 32'b00110);
    hps_complete("mount60");
    issue(1'b1, 1'b0, 32'h60);
    check("hit60", 32'(flags()), 32'b10000);
    @(negedge clk);
    bus_if.buf_addr    = 9'd9;
    bus_if.buf_wr_data = 8'h33;
    bus_if.buf_wr_en   = 1'b1;
    @(negedge clk);
    bus_if.buf_wr_en = 1'b0;
    issue(1'b1, 1'b0, 32'h60);
    check("dirty_miss", 32'(flags()), 32'b00110);
    hps_complete("dirty60");

    // Asynchronous reset mid RD_XFER, then mid RD_REQ
    issue(1'b1, 1'b0, 32'h50);
    bus_if.sd_ack = 1'b1;
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("rst_xfer_flags", 32'(flags()), 32'd0);
    check("rst_xfer_lba", bus_if.sd_lba, 32'd0);
    @(negedge clk);
    reset_n       = 1'b1;
    bus_if.sd_ack = 1'b0;
    issue(1'b1, 1'b0, 32'h51);
    check("rst_req_start", 32'(flags()), 32'b00110);
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check("rst_req_async", 32'(flags()), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fdc_sector_buffer.md
Name: fdc_sector_buffer

Overview:
SD-side responder for the floppy disk controller: serves whole-sector read/write requests from the FDC core against the mounted disk image over the MiSTer HPS sd block protocol. Holds one sector in local dual-port RAM. Exposes a byte-addressed buffer port to the FDC and the sd_lba/sd_rd/sd_wr/sd_ack/sd_buff_* handshake to the HPS. Caches the last sector so repeated reads of the same LBA complete without an HPS transfer.

Parameters:
SECTOR_BYTES, 512, bytes per sector; power of two.
ADDR_W, 9, log2(SECTOR_BYTES).
LBA_W, 32, sector address width.
TIMEOUT_CYCLES, 50000000, max cycles from request to sd_ack rise before abort.

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
req_rd  in  1  FDC: one-cycle pulse, load sector req_lba into buffer
req_wr  in  1  FDC: one-cycle pulse, write buffer to sector req_lba
req_lba  in  LBA_W  FDC: sector address, sampled with req_rd/req_wr
busy  out  1  transfer in progress
done  out  1  one-cycle pulse, request completed OK
error  out  1  one-cycle pulse, request failed
buf_addr  in  ADDR_W  FDC buffer byte address
buf_rd_data  out  8  RAM[buf_addr], 1-cycle latency
buf_wr_en  in  1  FDC buffer write strobe
buf_wr_data  in  8  FDC buffer write data
sd_lba  out  LBA_W  HPS: sector address
sd_rd  out  1  HPS: read request
sd_wr  out  1  HPS: write request
sd_ack  in  1  HPS: transfer active
sd_buff_addr  in  ADDR_W  HPS buffer byte address
sd_buff_dout  in  8  HPS -> buffer data
sd_buff_wr  in  1  HPS buffer write strobe
sd_buff_din  out  8  buffer -> HPS data, RAM[sd_buff_addr], 1-cycle latency
img_mounted  in  1  one-cycle pulse, image (re)mounted
img_present  in  1  image mounted, size nonzero
img_readonly  in  1  image write-protected

Behaviour:
- Reset: state IDLE; busy, done, error, sd_rd, sd_wr = 0; sd_lba = 0; cache_valid = 0; timeout counter = 0; buf_rd_data/sd_buff_din = 0. RAM contents undefined. Reset mid-transfer drops sd_rd/sd_wr asynchronously; the HPS transfer in flight is ignored.
- States: IDLE, RD_REQ, RD_XFER, WR_REQ, WR_XFER, FINISH.
- IDLE: req_rd and req_wr together -> read wins, write dropped. Requests outside IDLE are ignored (no done/error).
  - req_rd, !img_present -> error next cycle, stay IDLE.
  - req_rd, cache_valid, req_lba == cached_lba -> done next cycle, no HPS access.
  - req_rd otherwise -> sd_lba <= req_lba, sd_rd <= 1, busy <= 1, cache_valid <= 0, RD_REQ.
  - req_wr, (!img_present or img_readonly) -> error next cycle, stay IDLE.
  - req_wr otherwise -> sd_lba <= req_lba, sd_wr <= 1, busy <= 1, WR_REQ.
- RD_REQ/WR_REQ: hold sd_rd/sd_wr until first cycle sd_ack = 1, then deassert -> RD_XFER/WR_XFER. Timeout counter clears on entry, increments each cycle. At TIMEOUT_CYCLES-1 without ack: drop request, error pulse, busy <= 0, IDLE.
- RD_XFER: each sd_buff_wr writes RAM[sd_buff_addr] <= sd_buff_dout. Edge-detect sd_ack 1->0 -> FINISH.
- WR_XFER: sd_buff_din tracks RAM[sd_buff_addr] with 1-cycle latency; sd_buff_wr ignored. sd_ack 1->0 -> FINISH.
- FINISH (1 cycle): done pulse, busy <= 0, cached_lba <= sd_lba, cache_valid <= 1, IDLE. Total read latency after ack falls: 2 cycles to done.
- img_present falling during any non-IDLE state: abort as for timeout, cache_valid <= 0.
- img_mounted pulse: cache_valid <= 0 in any state; an in-flight transfer continues.
- FDC buffer port: reads always allowed. buf_wr_en honoured only when busy = 0; each accepted write clears cache_valid. The buffer is then dirty relative to cached_lba, so a later req_rd of that LBA refetches.
- sd_buff_addr and buf_addr index the full sector; no wrap handling beyond ADDR_W truncation.

Decomposition:
- Shared package (fdc_pkg): state enum fdc_sbuf_state_t, SECTOR_BYTES/ADDR_W defaults, LBA_W.
- One sub-module, sector_dpram: true dual-port SECTOR_BYTES x 8 RAM with registered reads. Port A = FDC, port B = HPS; both ports on clk.

Test Plan:
- Read miss: img_present=1, req_rd lba=0x12, HPS model acks after 10 cycles and writes bytes i^0x5A at addresses 0..511 -> sd_rd high exactly until ack. done 2 cycles after ack falls. buf_rd_data at addr 3 = 0x59.
- Cache hit: repeat req_rd lba=0x12 -> done next cycle, sd_rd never asserted. Then req_rd lba=0x13 -> sd_rd asserted.
- Write: FDC writes 0xA5 to all 512 bytes, req_wr lba=7 -> sd_wr until ack, HPS model reads 0xA5 at every address (1-cycle latency). Done pulse follows; later req_rd lba=7 hits.
- Protection: img_readonly=1, req_wr -> error next cycle, sd_wr stays 0. img_present=0, req_rd -> error, sd_rd stays 0.
- Timeout/abort: TIMEOUT_CYCLES=100, no ack -> error at cycle 100, sd_rd dropped. Separately, img_present falls in RD_XFER -> error, busy=0, a following same-LBA read refetches.
- Simultaneous/reset: req_rd and req_wr in the same cycle -> only sd_rd asserted. reset_n low mid RD_XFER -> sd_rd, busy, done, error all 0 immediately. req_rd during busy -> ignored.
